// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame size, device-side
// FSM state encoding and the parity helper.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int SYNC_LAT   = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_BUS_CHECK = 3'd1;
  localparam state_t S_HIGH      = 3'd2;
  localparam state_t S_LOW       = 3'd3;
  localparam state_t S_STOP_REL  = 3'd4;
  localparam state_t S_ABORT     = 3'd5;

  function automatic logic odd_par(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 CLK and DAT pins.
// Resets to the idle-high bus level.
module ps2_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clk_a_i,
  input  logic dat_a_i,
  output logic clk_s_o,
  output logic dat_s_o
);

  logic [1:0] clk_q;
  logic [1:0] dat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_q <= 2'b11;
      dat_q <= 2'b11;
    end else begin
      clk_q <= {clk_q[0], clk_a_i};
      dat_q <= {dat_q[0], dat_a_i};
    end
  end

  assign clk_s_o = clk_q[1];
  assign dat_s_o = dat_q[1];

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: generates CLK, shifts
// one 11-bit frame to the host, retries on inhibit.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int unsigned HALF_CYC   = 2000,
  parameter int unsigned IDLE_CYC   = 2500,
  parameter int unsigned SETTLE_CYC = 100
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       host_rts,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned MAXC =
    (HALF_CYC > IDLE_CYC) ? HALF_CYC : IDLE_CYC;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(MAXC);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] IDLE_END = CW'(IDLE_CYC - 1);
  // clk_s lags the pin by the synchronizer depth
  localparam logic [CW-1:0] ABT_FROM =
    CW'(SETTLE_CYC + SYNC_LAT);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic clk_s;
  logic dat_s;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [3:0]            nbit;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  clk_oe_q, clk_oe_d;
  logic                  dat_oe_q, dat_oe_d;
  logic                  done_q, done_d;

  ps2_sync u_sync (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .clk_a_i (ps2_clk_i),
    .dat_a_i (ps2_dat_i),
    .clk_s_o (clk_s),
    .dat_s_o (dat_s)
  );

  assign nbit = bit_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_valid) begin
          shift_d = {1'b1, odd_par(tx_data),
                     tx_data, 1'b0};
          state_d = S_BUS_CHECK;
        end
      end
      S_BUS_CHECK: begin
        if (!(clk_s && dat_s)) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_END) begin
          state_d  = S_HIGH;
          cnt_d    = '0;
          bit_d    = '0;
          dat_oe_d = ~shift_q[0];
        end
      end
      S_HIGH: begin
        if (!clk_s && cnt_q >= ABT_FROM) begin
          state_d  = S_ABORT;
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
        end else if (cnt_q == HALF_END) begin
          state_d  = S_LOW;
          cnt_d    = '0;
          clk_oe_d = 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_q == HALF_END) begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          if (bit_q == LAST_BIT) begin
            state_d  = S_STOP_REL;
            dat_oe_d = 1'b0;
          end else begin
            state_d  = S_HIGH;
            bit_d    = nbit;
            dat_oe_d = ~shift_q[nbit];
          end
        end
      end
      S_STOP_REL: begin
        if (cnt_q == HALF_END) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      S_ABORT: begin
        state_d = S_BUS_CHECK;
        cnt_d   = '0;
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
    end
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = ~tx_ready;
  assign tx_done    = done_q;
  assign tx_abort   = (state_q == S_ABORT);
  assign host_rts   = (state_q == S_IDLE ||
                       state_q == S_BUS_CHECK) &&
                      clk_s && !dat_s;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule
